// File: rtl/dt1_pkg.sv
// Shared definitions for the dt1 RV32I pipeline.
package dt1_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR        = 32'h0000_0013;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Forces a fetch address onto a word boundary.
  function automatic word_t align_word(input word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/dt1_fetch_if.sv
// Instruction-memory request/grant/response channel used by dt1_fetch.
interface dt1_fetch_if;
  import dt1_pkg::*;

  logic  req;
  word_t addr;
  logic  gnt;
  logic  rvalid;
  word_t rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/dt1_fetch_queue.sv
// In-order prefetch queue: entry storage, pointers, filled bits, occupancy and
// the response bypass onto the head.
module dt1_fetch_queue import dt1_pkg::*; #(
  parameter  int unsigned QDEPTH = 2,
  localparam int unsigned PW     = $clog2(QDEPTH),
  localparam int unsigned CW     = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          alloc,
  input  word_t         alloc_pc,
  input  logic          fill,
  input  word_t         fill_data,
  input  logic          pop,
  output logic          head_ready,
  output word_t         head_pc,
  output word_t         head_instr,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);

  word_t             pc_mem    [QDEPTH];
  word_t             instr_mem [QDEPTH];
  logic [QDEPTH-1:0] valid;
  logic [QDEPTH-1:0] filled;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     fptr;
  logic              fill_ok;
  logic              fill_head;

  // fptr always names the oldest unfilled entry, or the tail when none exist.
  assign fill_ok    = fill && valid[fptr] && !filled[fptr];
  assign fill_head  = fill_ok && (fptr == head);
  assign head_ready = valid[head] && (filled[head] || fill_head);
  assign head_pc    = pc_mem[head];
  assign head_instr = filled[head] ? instr_mem[head] : fill_data;

  always_comb begin
    unfilled = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (valid[i] && !filled[i]) unfilled = unfilled + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      fptr   <= '0;
      valid  <= '0;
      filled <= '0;
      count  <= '0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      fptr   <= '0;
      valid  <= '0;
      filled <= '0;
      count  <= '0;
    end else begin
      count <= count + CW'(alloc) - CW'(pop);
      if (fill_ok) begin
        filled[fptr] <= 1'b1;
        fptr         <= fptr + 1'b1;
      end
      // A bypassed head is popped in the same cycle, so pop must override fill.
      if (pop) begin
        valid[head]  <= 1'b0;
        filled[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (alloc) begin
        valid[tail]  <= 1'b1;
        filled[tail] <= 1'b0;
        tail         <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc && !flush) pc_mem[tail]    <= alloc_pc;
    if (fill_ok && !flush) instr_mem[fptr] <= fill_data;
  end

endmodule

// File: rtl/dt1_fetch.sv
// dt1 instruction-fetch stage: fetch PC, request issue, stale-response drop
// accounting and the decode register.
module dt1_fetch import dt1_pkg::*; #(
  parameter  word_t       RESET_PC = DEFAULT_RESET_PC,
  parameter  int unsigned QDEPTH   = 2,
  localparam int unsigned CW       = $clog2(QDEPTH) + 1,
  localparam int unsigned SW       = CW + 1
) (
  input  logic               clk,
  input  logic               reset,
  dt1_fetch_if.master        imem,
  input  logic               StallD,
  input  logic               PCSrcE,
  input  word_t              PCTargetE,
  output word_t              InstrD,
  output word_t              PCD,
  output word_t              PCPlus4D,
  output logic               ValidD
);

  word_t         pcf;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] count;
  logic [CW-1:0] unfilled;
  logic          head_ready;
  word_t         head_pc;
  word_t         head_instr;
  logic          alloc;
  logic          keep;
  logic          pop;

  // Responses still owed to flushed requests count against capacity.
  assign imem.req  = !reset && !PCSrcE && ((SW'(count) + SW'(drop)) < SW'(QDEPTH));
  assign imem.addr = pcf;

  assign alloc = imem.req && imem.gnt;
  assign keep  = imem.rvalid && (drop == '0);
  assign pop   = !PCSrcE && !StallD && head_ready;

  always_comb begin
    drop_next = drop;
    if (imem.rvalid && (drop != '0)) drop_next = drop - CW'(1);
    if (PCSrcE) drop_next = drop_next + unfilled - CW'(keep);
  end

  dt1_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (PCSrcE),
    .alloc      (alloc),
    .alloc_pc   (pcf),
    .fill       (keep),
    .fill_data  (imem.rdata),
    .pop        (pop),
    .head_ready (head_ready),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count),
    .unfilled   (unfilled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf      <= RESET_PC;
      drop     <= '0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      drop <= drop_next;
      if (PCSrcE) begin
        pcf    <= align_word(PCTargetE);
        ValidD <= 1'b0;
      end else begin
        if (alloc) pcf <= pcf + word_t'(4);
        if (!StallD) begin
          if (head_ready) begin
            InstrD   <= head_instr;
            PCD      <= head_pc;
            PCPlus4D <= head_pc + word_t'(4);
            ValidD   <= 1'b1;
          end else begin
            ValidD   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dt1_fetch.sv
// Self-checking bench for dt1_fetch: queue-based reference model plus a
// latency-randomised in-order instruction memory.
module tb_dt1_fetch;
  import dt1_pkg::*;

  localparam int unsigned QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  dt1_fetch_if bus ();

  dt1_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (bus),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_pcf, m_instr, m_pcd, m_pcp4;
  bit          m_valid;
  int unsigned m_drop;

  bit          k_reset, k_stall, k_pcsrc;
  logic [31:0] k_tgt;
  int unsigned k_gnt_pct, k_rv_pct, k_lat;
  bit          cur_gnt, cur_rv;
  logic [31:0] cur_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_req();
    return !k_reset && !k_pcsrc && ((mq.size() + m_drop) < QD);
  endfunction

  task automatic model_reset();
    m_pcf   = RPC;
    mq.delete();
    memq.delete();
    m_drop  = 0;
    m_instr = 32'h0000_0013;
    m_pcd   = 0;
    m_pcp4  = 0;
    m_valid = 0;
  endtask

  // Response fills the oldest waiting entry first; a filled head is then
  // eligible for decode in the same cycle, which covers the bypass case.
  task automatic model_step();
    bit          req;
    bit          found;
    int unsigned unf;
    req   = model_req();
    found = 0;
    if (cur_rv) begin
      if (m_drop > 0) m_drop--;
      else begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!found && !mq[i].filled) begin
            mq[i].instr  = cur_rdata;
            mq[i].filled = 1;
            found        = 1;
          end
        end
      end
    end
    if (k_pcsrc) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      m_drop += unf;
      mq.delete();
      m_valid = 0;
      m_pcf   = {k_tgt[31:2], 2'b00};
    end else begin
      if (!k_stall) begin
        if (mq.size() > 0 && mq[0].filled) begin
          m_instr = mq[0].instr;
          m_pcd   = mq[0].pc;
          m_pcp4  = mq[0].pc + 32'd4;
          m_valid = 1;
          void'(mq.pop_front());
        end else begin
          m_valid = 0;
        end
      end
      if (req && cur_gnt) begin
        mq.push_back('{pc: m_pcf, instr: 32'h0, filled: 0});
        memq.push_back('{addr: m_pcf, due: cyc + 1 + $urandom_range(0, k_lat)});
        m_pcf = m_pcf + 32'd4;
      end
    end
  endtask

  task automatic drive_and_check();
    @(negedge clk);
    reset     = k_reset;
    StallD    = k_stall;
    PCSrcE    = k_pcsrc;
    PCTargetE = k_tgt;
    cur_gnt   = ($urandom_range(0, 99) < k_gnt_pct);
    cur_rv    = 0;
    if (!k_reset && memq.size() > 0) begin
      if (memq[0].due <= cyc && $urandom_range(0, 99) < k_rv_pct) cur_rv = 1;
    end
    cur_rdata  = cur_rv ? mem_word(memq[0].addr) : $urandom;
    bus.gnt    = cur_gnt;
    bus.rvalid = cur_rv;
    bus.rdata  = cur_rdata;
    #1;
    check("imem_req", 32'(bus.req), 32'(model_req()));
    check("imem_addr", bus.addr, m_pcf);
    check("ValidD", 32'(ValidD), 32'(m_valid));
    check("InstrD", InstrD, m_instr);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pcp4);
  endtask

  task automatic advance();
    if (k_reset) model_reset();
    else begin
      if (cur_rv) void'(memq.pop_front());
      model_step();
    end
    cyc++;
  endtask

  task automatic cycle();
    drive_and_check();
    advance();
  endtask

  task automatic find_valid(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_p4);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_and_check();
      if (ValidD === 1'b1) begin
        seen = 1;
        check({name, "_pcd"}, PCD, exp_pc);
        check({name, "_pcplus4"}, PCPlus4D, exp_p4);
      end
      advance();
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: ValidD never rose, required pc %h", name, exp_pc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; StallD = 0; PCSrcE = 0; PCTargetE = 0;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
    k_reset = 1; k_stall = 0; k_pcsrc = 0; k_tgt = 0;
    k_gnt_pct = 100; k_rv_pct = 100; k_lat = 0;
    model_reset();

    drive_and_check();
    check("rst_imem_req", 32'(bus.req), 32'd0);
    check("rst_ValidD", 32'(ValidD), 32'd0);
    check("rst_InstrD", InstrD, 32'h0000_0013);
    advance();
    cycle();

    // Zero-wait stream from the reset PC.
    k_reset = 0;
    for (int i = 0; i < 10; i++) begin
      drive_and_check();
      if (i == 0) begin
        check("first_req", 32'(bus.req), 32'd1);
        check("first_addr", bus.addr, 32'h0000_0100);
      end
      if (i >= 2) begin
        check("stream_valid", 32'(ValidD), 32'd1);
        check("stream_pcd", PCD, 32'h100 + 32'(4 * (i - 2)));
        check("stream_instr", InstrD, (32'h100 + 32'(4 * (i - 2))) ^ 32'hA5A5_0000);
      end
      advance();
    end

    // Decode stall: queue fills to QDEPTH and D is frozen.
    k_stall = 1;
    for (int j = 0; j < 4; j++) begin
      drive_and_check();
      check("stall_pcd", PCD, 32'h0000_0120);
      check("stall_valid", 32'(ValidD), 32'd1);
      if (j >= 1) check("stall_req_low", 32'(bus.req), 32'd0);
      advance();
    end
    k_stall = 0;
    cycle();
    drive_and_check();
    check("post_stall_pcd1", PCD, 32'h0000_0124);
    advance();
    drive_and_check();
    check("post_stall_pcd2", PCD, 32'h0000_0128);
    advance();

    // Drain, put two requests in flight, then redirect to 0x200.
    k_gnt_pct = 0;
    repeat (6) cycle();
    k_gnt_pct = 100; k_rv_pct = 0;
    repeat (2) cycle();
    k_pcsrc = 1; k_tgt = 32'h0000_0200;
    cycle();
    k_pcsrc = 0; k_rv_pct = 100;
    drive_and_check();
    check("redir_valid_low", 32'(ValidD), 32'd0);
    check("redir_addr", bus.addr, 32'h0000_0200);
    check("redir_req_blocked", 32'(bus.req), 32'd0);
    advance();
    find_valid("redir_200", 32'h0000_0200, 32'h0000_0204);

    // Redirect, stall and a live response in one cycle with two unfilled.
    repeat (4) cycle();
    k_stall = 1; k_rv_pct = 0;
    cycle();
    k_pcsrc = 1; k_tgt = 32'h0000_0302; k_rv_pct = 100;
    cycle();
    k_pcsrc = 0; k_stall = 0;
    drive_and_check();
    check("combo_valid_bubble", 32'(ValidD), 32'd0);
    check("combo_drop", 32'(dut.drop), 32'd1);
    check("combo_aligned_addr", bus.addr, 32'h0000_0300);
    advance();
    find_valid("redir_302", 32'h0000_0300, 32'h0000_0304);

    // PC wrap at the top of the address space.
    repeat (3) cycle();
    k_pcsrc = 1; k_tgt = 32'hFFFF_FFFC;
    cycle();
    k_pcsrc = 0;
    find_valid("wrap", 32'hFFFF_FFFC, 32'h0000_0000);
    drive_and_check();
    check("wrap_next_pcd", PCD, 32'h0000_0000);
    check("wrap_next_pcplus4", PCPlus4D, 32'h0000_0004);
    advance();
    repeat (3) cycle();

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    reset = 1;
    k_reset = 1;
    model_reset();
    #1;
    check("async_rst_valid", 32'(ValidD), 32'd0);
    check("async_rst_instr", InstrD, 32'h0000_0013);
    check("async_rst_req", 32'(bus.req), 32'd0);
    check("async_rst_pcd", PCD, 32'h0);
    check("async_rst_pcplus4", PCPlus4D, 32'h0);
    repeat (2) cycle();
    k_reset = 0;
    drive_and_check();
    check("rerelease_addr", bus.addr, 32'h0000_0100);
    check("rerelease_req", 32'(bus.req), 32'd1);
    advance();

    // Randomised traffic against the model.
    k_lat = 2;
    for (int n = 0; n < 3000; n++) begin
      k_stall   = ($urandom_range(0, 3) == 0);
      k_pcsrc   = ($urandom_range(0, 19) == 0);
      k_tgt     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      k_gnt_pct = 70;
      k_rv_pct  = 70;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
